seq_multiplier: RTL and testbench
=================================

Name: seq_multiplier

Overview:
- Multi-cycle shift-add multiplier for the MIPS MULT/MULTU path.
- Sits directly upstream of the HI/LO register bank: consumes operands A and B, produces a 2*WIDTH product, and asserts Done so the HI/LO D flip-flops can capture Hi and Lo with their enable.
- One add/shift iteration per clock. The caller stalls on Busy.

Parameters:
- WIDTH, 32, operand width in bits. Must be ≥ 2; the product is 2*WIDTH bits.

Ports:
- Clk  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-high reset
- Start  in  1  request a multiply; sampled only in IDLE or DONE
- Signed  in  1  1 = MULT (two's complement), 0 = MULTU; sampled with Start
- A  in  WIDTH  multiplicand; sampled with Start
- B  in  WIDTH  multiplier; sampled with Start
- Busy  out  1  operation in progress (RUN or FIX)
- Done  out  1  one-cycle pulse; Hi and Lo are valid from this cycle
- Hi  out  WIDTH  upper half of the product, registered
- Lo  out  WIDTH  lower half of the product, registered

Behaviour:
- Clock and reset: one clock, Clk. Reset is asynchronous and active-high.
- Reset values: state = IDLE, Busy = 0, Done = 0, Hi = 0, Lo = 0. The working registers and the counter are also cleared.
- State IDLE:
  - If Start = 1 at the edge, latch the operands:
    - Mcand = |A| if Signed, else A.
    - Work = {(WIDTH+1)'b0, |B| if Signed, else B}.
    - NegRes = Signed & (A[msb] ^ B[msb]).
    - Count = 0.
  - Then go to RUN.
- State RUN (one iteration per edge):
  - If Work[0] = 1, add Mcand to Work[2W:W], using a W+1-bit add that keeps the carry.
  - Logical shift of Work right by 1.
  - Count += 1.
  - After WIDTH iterations, go to FIX.
- State FIX:
  - Load {Hi,Lo} = NegRes ? -Work[2W-1:0] : Work[2W-1:0], two's complement over 2W bits.
  - Go to DONE.
- State DONE:
  - Done = 1 for exactly this cycle. Next edge goes to IDLE.
  - If Start = 1 at that edge, the request is accepted exactly as in IDLE (back-to-back operation).
- Latency:
  - Start sampled at edge E0; Busy = 1 from E0 until E(WIDTH+1).
  - Hi/Lo update at E(WIDTH+1); Done is high for the cycle after E(WIDTH+1). That is WIDTH+1 edges, 33 for WIDTH = 32.
- Hi and Lo hold the previous result throughout RUN and FIX. They change only in FIX or on Reset.
- Start during RUN or FIX is ignored; it is neither queued nor an error.
- Absolute-value edge case: |most-negative| is taken as a W-bit unsigned value, so 0x80000000 → 0x80000000, which is correct unsigned.
- Count width is $clog2(WIDTH)+1 bits. It must not wrap before it reaches WIDTH.
- Reset mid-operation: abort immediately. No Done pulse. Hi and Lo go to 0. The next Start after Reset deasserts behaves normally.
- A and B may change freely after the Start edge.

Optional Feature:
- Macro: SEQ_MULT_SIGNED_EN.
- Defined: the Signed port is honoured as described above; the absolute-value and negation logic is present.
- Not defined: the Signed port is still present but ignored. Every operation is unsigned, NegRes is forced to 0, and no negators are synthesized. Latency is unchanged.

Decomposition:
- Shared package mult_pkg:
  - state enum {IDLE, RUN, FIX, DONE}
  - MULT_WIDTH_DEFAULT = 32
  - a count-width function
- Sub-module seq_multiplier_ctrl:
  - FSM plus counter
  - outputs: Busy, Done, load, step and fix strobes
- The datapath (Mcand, Work, adder, negator) stays in seq_multiplier.

Test Plan:
- Unsigned, A = 3, B = 5: Done exactly 33 edges after Start; Hi = 0x00000000, Lo = 0x0000000F; Busy low again after Done.
- Unsigned, A = B = 0xFFFFFFFF: Hi = 0xFFFFFFFE, Lo = 0x00000001.
- Signed, A = 0xFFFFFFFD (−3), B = 5: Hi = 0xFFFFFFFF, Lo = 0xFFFFFFF1. Then A = B = 0x80000000 signed: Hi = 0x40000000, Lo = 0x00000000. Without SEQ_MULT_SIGNED_EN, A = 0xFFFFFFFD, B = 5 gives Hi = 0x00000004, Lo = 0xFFFFFFF1.
- Start pulsed again at edge 10 of a run, with different A and B: ignored; the result matches the first operands, and only one Done pulse occurs.
- Reset asserted asynchronously at cycle 10 of a run: Busy = 0, Hi = Lo = 0 immediately, no Done. A new Start with 7*6 then gives Lo = 42 after 33 edges.
- Start held high during the DONE cycle with A = 2, B = 9: back-to-back accept. First result held; second Done 33 edges later with Lo = 18.

Source files
------------

// File: rtl/seq_multiplier_pkg.sv
// Shared definitions for the sequential shift-add multiplier (package mult_pkg).
// Optional signed support is selected in seq_multiplier by SEQ_MULT_SIGNED_EN.
package mult_pkg;

  // Controller states; Busy covers RUN and FIX, Done is the DONE cycle.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam int MULT_WIDTH_DEFAULT = 32;

  // Iteration counter width: one extra bit so the count can reach WIDTH
  // without wrapping.
  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/seq_multiplier_ctrl.sv
// Sequencer for the shift-add multiplier: IDLE -> RUN (WIDTH steps) -> FIX
// -> DONE. Issues load/step/fix strobes to the datapath in seq_multiplier.
// Handshake: start_i is a request that is accepted only in IDLE or DONE; a
// request seen in RUN or FIX is dropped. busy_o is high while a request is in
// flight, done_o is a single-cycle pulse once the result registers are valid.
module seq_multiplier_ctrl
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH_DEFAULT
) (
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   start_i,
  output logic   busy_o,
  output logic   done_o,
  output logic   load_o,
  output logic   step_o,
  output logic   fix_o,
  output state_e state_o
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] count_q, count_d;

  // State and iteration counter registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Next-state logic and datapath strobes.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    load_o  = 1'b0;
    step_o  = 1'b0;
    fix_o   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          load_o  = 1'b1;
          count_d = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        step_o  = 1'b1;
        count_d = count_q + 1'b1;
        // The step taken on this edge is the last one.
        if (count_q == LAST_STEP) begin
          state_d = FIX;
        end
      end
      FIX: begin
        fix_o   = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        // A request here is taken exactly as in IDLE.
        if (start_i) begin
          load_o  = 1'b1;
          count_d = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy_o  = (state_q == RUN) || (state_q == FIX);
  assign done_o  = (state_q == DONE);
  assign state_o = state_q;

endmodule

// File: rtl/seq_multiplier.sv
// Multi-cycle shift-add multiplier for the MULT/MULTU path feeding HI/LO.
// One add/shift per clock; Done pulses once Hi/Lo hold the new product.
// Define SEQ_MULT_SIGNED_EN to honour the Signed input (magnitude multiply
// plus final negate); without it every operation is unsigned.
module seq_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH_DEFAULT
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Signed,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  logic   load, step, fix;
  state_e ctrl_state;

  // Working registers: Work[2W:W] accumulates partial sums, Work[W-1:0]
  // starts as the multiplier and is shifted out one bit per step.
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH:0]   work_q, work_d;
  logic               neg_q, neg_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic [WIDTH-1:0]   a_mag, b_mag;
  logic               neg_in;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] result;

  seq_multiplier_ctrl #(
    .WIDTH (WIDTH)
  ) u_ctrl (
    .clk_i   (Clk),
    .rst_i   (Reset),
    .start_i (Start),
    .busy_o  (Busy),
    .done_o  (Done),
    .load_o  (load),
    .step_o  (step),
    .fix_o   (fix),
    .state_o (ctrl_state)
  );

  // Operand conditioning. |most-negative| stays as the same W-bit pattern,
  // which is the correct unsigned magnitude.
  always_comb begin
`ifdef SEQ_MULT_SIGNED_EN
    a_mag  = (Signed && A[WIDTH-1]) ? (~A + 1'b1) : A;
    b_mag  = (Signed && B[WIDTH-1]) ? (~B + 1'b1) : B;
    neg_in = Signed & (A[WIDTH-1] ^ B[WIDTH-1]);
`else
    a_mag  = A;
    b_mag  = B;
    neg_in = 1'b0;
`endif
  end

  // Adder keeps the carry so the W+1-bit upper half never overflows.
  assign sum  = work_q[2*WIDTH:WIDTH] + {1'b0, mcand_q};
  assign prod = work_q[2*WIDTH-1:0];

  // Final sign correction of the magnitude product.
  always_comb begin
`ifdef SEQ_MULT_SIGNED_EN
    result = neg_q ? (~prod + 1'b1) : prod;
`else
    result = prod;
`endif
  end

  // Datapath next-state: load operands, add/shift, or capture the result.
  always_comb begin
    mcand_d = mcand_q;
    work_d  = work_q;
    neg_d   = neg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    if (load) begin
      mcand_d = a_mag;
      work_d  = {{(WIDTH+1){1'b0}}, b_mag};
      neg_d   = neg_in;
    end else if (step) begin
      if (work_q[0]) begin
        work_d = {1'b0, sum, work_q[WIDTH-1:1]};
      end else begin
        work_d = {1'b0, work_q[2*WIDTH:1]};
      end
    end
    if (fix) begin
      {hi_d, lo_d} = result;
    end
  end

  // Datapath registers; Hi/Lo change only on a FIX cycle or reset.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      mcand_q <= '0;
      work_q  <= '0;
      neg_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      mcand_q <= mcand_d;
      work_q  <= work_d;
      neg_q   <= neg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign Hi = hi_q;
  assign Lo = lo_q;

  // Debug state and, in the unsigned build, Signed/neg_q have no load here.
  logic unused_ok;
  assign unused_ok = ^{1'b0, Signed, neg_q, ctrl_state};

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed plus random bench for seq_multiplier (WIDTH = 32).
module tb_seq_multiplier;

  localparam int W   = 32;
  localparam int LAT = W + 1;

  logic         Clk;
  logic         Reset;
  logic         Start;
  logic         Signed;
  logic [W-1:0] A, B;
  logic         Busy, Done;
  logic [W-1:0] Hi, Lo;

  int n_vec;
  int n_err;

  logic [W-1:0] exp_hi, exp_lo;
  logic [W-1:0] prev_hi, prev_lo;
  logic [2*W-1:0] exp_q[$];

  seq_multiplier #(.WIDTH(W)) dut (
    .Clk    (Clk),
    .Reset  (Reset),
    .Start  (Start),
    .Signed (Signed),
    .A      (A),
    .B      (B),
    .Busy   (Busy),
    .Done   (Done),
    .Hi     (Hi),
    .Lo     (Lo)
  );

  // Clock
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Reference product from plain integer arithmetic.
  function automatic logic [2*W-1:0] model(input logic [W-1:0] a,
                                           input logic [W-1:0] b,
                                           input logic s);
    longint sa, sb;
    sa = 0;
    sb = 0;
`ifdef SEQ_MULT_SIGNED_EN
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
`endif
    return {32'd0, a} * {32'd0, b};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present a request before the next rising edge; returns after that edge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    @(negedge Clk);
    A = a; B = b; Signed = s; Start = 1'b1;
    exp_q.push_back(model(a, b, s));
    @(posedge Clk);
    #1;
    Start = 1'b0;
    A = $urandom; B = $urandom; Signed = $urandom_range(0, 1);
  endtask

  // Wait for Done after the accepting edge; checks Hi/Lo hold mid-run.
  task automatic wait_done(output int edges);
    edges = -1;
    for (int i = 1; i <= 100; i++) begin
      @(posedge Clk);
      #1;
      if (i == 10) begin
        chk("busy_mid", {63'd0, Busy}, 64'd1);
        chk("hold_mid", {Hi, Lo}, {prev_hi, prev_lo});
      end
      if (Done) begin
        edges = i;
        break;
      end
    end
  endtask

  task automatic check_result(input string tag);
    logic [2*W-1:0] e;
    if (exp_q.size() == 0) begin
      chk({tag, "_queue"}, 64'd0, 64'd1);
      return;
    end
    e = exp_q.pop_front();
    {exp_hi, exp_lo} = e;
    chk({tag, "_hi"}, {32'd0, Hi}, {32'd0, exp_hi});
    chk({tag, "_lo"}, {32'd0, Lo}, {32'd0, exp_lo});
    prev_hi = exp_hi;
    prev_lo = exp_lo;
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic s);
    int edges;
    issue(a, b, s);
    chk({tag, "_busy0"}, {63'd0, Busy}, 64'd1);
    wait_done(edges);
    chk({tag, "_lat"}, 64'(edges), 64'(LAT));
    check_result(tag);
    @(posedge Clk);
    #1;
    chk({tag, "_done_clr"}, {62'd0, Busy, Done}, 64'd0);
  endtask

  initial begin
    int edges;
    int pulses;
    n_vec = 0;
    n_err = 0;
    prev_hi = '0;
    prev_lo = '0;
    Reset = 1'b1; Start = 1'b0; Signed = 1'b0; A = '0; B = '0;

    // Reset state
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_state", {Busy, Done, Hi, Lo}, 64'd0);
    @(negedge Clk);
    Reset = 1'b0;

    // Directed products
    run_op("u3x5", 32'd3, 32'd5, 1'b0);
    chk("u3x5_const", {Hi, Lo}, 64'h0000_0000_0000_000F);
    run_op("uffxff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    chk("uffxff_const", {Hi, Lo}, 64'hFFFF_FFFE_0000_0001);
    run_op("sm3x5", 32'hFFFF_FFFD, 32'd5, 1'b1);
`ifdef SEQ_MULT_SIGNED_EN
    chk("sm3x5_const", {Hi, Lo}, 64'hFFFF_FFFF_FFFF_FFF1);
`else
    chk("sm3x5_const", {Hi, Lo}, 64'h0000_0004_FFFF_FFF1);
`endif
    run_op("s8x8", 32'h8000_0000, 32'h8000_0000, 1'b1);
    chk("s8x8_const", {Hi, Lo}, 64'h4000_0000_0000_0000);

    // Start during RUN is ignored
    issue(32'd1234, 32'd5678, 1'b0);
    pulses = 0;
    edges = -1;
    for (int i = 1; i <= 45; i++) begin
      if (i == 10) begin
        @(negedge Clk);
        A = 32'd99; B = 32'd77; Start = 1'b1;
      end
      @(posedge Clk);
      #1;
      if (i == 10) Start = 1'b0;
      if (Done) begin
        pulses++;
        if (edges < 0) begin
          edges = i;
          check_result("ign");
        end
      end
    end
    chk("ign_lat", 64'(edges), 64'(LAT));
    chk("ign_pulses", 64'(pulses), 64'd1);

    // Asynchronous reset mid-run
    issue(32'hDEAD_BEEF, 32'h1234_5678, 1'b0);
    void'(exp_q.pop_back());
    repeat (9) @(posedge Clk);
    #2;
    Reset = 1'b1;
    #1;
    chk("arst_out", {Busy, Done, Hi, Lo}, 64'd0);
    prev_hi = '0;
    prev_lo = '0;
    @(negedge Clk);
    Reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge Clk);
      #1;
      if (Done || Busy) pulses++;
    end
    chk("arst_quiet", 64'(pulses), 64'd0);
    run_op("r7x6", 32'd7, 32'd6, 1'b0);
    chk("r7x6_const", {32'd0, Lo}, 64'd42);

    // Back-to-back accept in the DONE cycle
    issue(32'd11, 32'd13, 1'b0);
    wait_done(edges);
    chk("b2b1_lat", 64'(edges), 64'(LAT));
    check_result("b2b1");
    A = 32'd2; B = 32'd9; Signed = 1'b0; Start = 1'b1;
    exp_q.push_back(model(32'd2, 32'd9, 1'b0));
    @(posedge Clk);
    #1;
    Start = 1'b0;
    chk("b2b_busy", {62'd0, Busy, Done}, 64'd2);
    chk("b2b_hold", {Hi, Lo}, {prev_hi, prev_lo});
    wait_done(edges);
    chk("b2b2_lat", 64'(edges), 64'(LAT));
    check_result("b2b2");
    chk("b2b2_const", {32'd0, Lo}, 64'd18);
    @(posedge Clk);
    #1;

    // Random operands
    for (int k = 0; k < 16; k++) begin
      logic [W-1:0] ra, rb;
      ra = $urandom;
      rb = $urandom;
      if (k % 4 == 0) ra = 32'h8000_0000;
      if (k % 5 == 1) rb = 32'hFFFF_FFFF;
      run_op("rand", ra, rb, 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
